bouncing_box_renderer: RTL and testbench

- Pixel source feeding the VGA timing interface's COLOUR_IN. It consumes the current pixel address (ADDRH/ADDRV), the pixel-enable strobe (DOWNCOUNTER) and the frame REFRESH pulse.
- Renders a solid rectangle over a background colour and returns one registered RGB332 byte per enabled pixel.
- Once per frame it moves the box, bouncing off the screen edges. It also advances a 4-entry box palette on every wall hit.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/bouncing_box_renderer_if.sv | 29 ++
 rtl/bounce_axis.sv | 74 +++++++
 rtl/bouncing_box_renderer.sv | 105 ++++++++++
 tb/tb_bouncing_box_renderer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared VGA constants, RGB332 colours, direction and motion codes.
// Revision : 1.0
// ============================================================================
package vga_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  localparam logic [7:0] RGB_BLACK = 8'h00;
  localparam logic [7:0] RGB_RED   = 8'hE0;
  localparam logic [7:0] RGB_GREEN = 8'h1C;
  localparam logic [7:0] RGB_BLUE  = 8'h03;
  localparam logic [7:0] RGB_WHITE = 8'hFF;

  // Positive direction is RIGHT on X and DOWN on Y.
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } motion_e;

endpackage
`default_nettype wire

// File: rtl/bouncing_box_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : bouncing_box_renderer_if
// Brief    : Pixel/frame bus between the VGA timing side and the box renderer.
// Revision : 1.0
// ============================================================================
interface bouncing_box_renderer_if;
  logic       PIX_EN;
  logic       REFRESH;
  logic [9:0] ADDRH;
  logic [8:0] ADDRV;
  logic       PAUSE;
  logic [7:0] COLOUR;
  logic [9:0] BOX_X;
  logic [8:0] BOX_Y;
  logic       HIT;
  logic       CORNER;

  modport master (
    output PIX_EN, REFRESH, ADDRH, ADDRV, PAUSE,
    input  COLOUR, BOX_X, BOX_Y, HIT, CORNER
  );

  modport slave (
    input  PIX_EN, REFRESH, ADDRH, ADDRV, PAUSE,
    output COLOUR, BOX_X, BOX_Y, HIT, CORNER
  );
endinterface
`default_nettype wire

// File: rtl/bounce_axis.sv
`default_nettype none
// ============================================================================
// Module   : bounce_axis
// Brief    : One axis of box motion; clamps to [0, MAX] and reverses on a wall.
// Revision : 1.0
// ============================================================================
module bounce_axis
  import vga_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int MAX   = 608,
  parameter int STEP  = 4,
  parameter int INIT  = 304
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             UPDATE,
  output logic [WIDTH-1:0] POS,
  output logic             DIR,
  output logic             HIT_PULSE
);

  localparam logic [10:0]      MAX_W  = 11'(MAX);
  localparam logic [10:0]      STEP_W = 11'(STEP);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

  logic [WIDTH-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [10:0]      pos_ext;
  logic [10:0]      sum;

  // 11-bit compare keeps pos+STEP from wrapping near the upper limit.
  always_comb begin
    pos_ext   = 11'(pos_q);
    sum       = pos_ext + STEP_W;
    pos_d     = pos_q;
    dir_d     = dir_q;
    HIT_PULSE = 1'b0;
    if (UPDATE) begin
      if (dir_q == DIR_POS) begin
        if (sum >= MAX_W) begin
          pos_d     = MAX_W[WIDTH-1:0];
          dir_d     = DIR_NEG;
          HIT_PULSE = 1'b1;
        end else begin
          pos_d = sum[WIDTH-1:0];
        end
      end else begin
        if (pos_ext <= STEP_W) begin
          pos_d     = '0;
          dir_d     = DIR_POS;
          HIT_PULSE = 1'b1;
        end else begin
          pos_d = pos_q - STEP_W[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pos_q <= INIT_W;
      dir_q <= DIR_POS;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign POS = pos_q;
  assign DIR = dir_q;

endmodule
`default_nettype wire

// File: rtl/bouncing_box_renderer.sv
`default_nettype none
// ============================================================================
// Module   : bouncing_box_renderer
// Brief    : Renders a bouncing solid box over a background, RGB332 per pixel.
// Revision : 1.0
// ============================================================================
module bouncing_box_renderer
  import vga_pkg::*;
#(
  parameter int         H_RES     = H_RES_DEF,
  parameter int         V_RES     = V_RES_DEF,
  parameter int         BOX_W     = 32,
  parameter int         BOX_H     = 32,
  parameter int         STEP      = 4,
  parameter int         INIT_X    = 304,
  parameter int         INIT_Y    = 224,
  parameter logic [7:0] BG_COLOUR = RGB_BLACK,
  parameter logic [7:0] PAL0      = RGB_RED,
  parameter logic [7:0] PAL1      = RGB_GREEN,
  parameter logic [7:0] PAL2      = RGB_BLUE,
  parameter logic [7:0] PAL3      = RGB_WHITE
) (
  input logic                     CLK,
  input logic                     RST_N,
  bouncing_box_renderer_if.slave  bus
);

  localparam int          X_MAX   = H_RES - BOX_W;
  localparam int          Y_MAX   = V_RES - BOX_H;
  localparam logic [10:0] BOX_W_W = 11'(BOX_W);
  localparam logic [10:0] BOX_H_W = 11'(BOX_H);

  motion_e    state_q, state_d;
  logic [1:0] pal_q, pal_d;
  logic       hit_q, hit_d;
  logic       corner_q, corner_d;
  logic [7:0] colour_q, colour_d;

  logic       update;
  logic [9:0] box_x;
  logic [8:0] box_y;
  logic       dir_x, dir_y;
  logic       x_hit, y_hit;
  logic       in_box;
  logic [7:0] box_colour;

  assign update = bus.REFRESH && (state_q == ST_RUN);

  bounce_axis #(.WIDTH(10), .MAX(X_MAX), .STEP(STEP), .INIT(INIT_X)) u_axis_x (
    .CLK(CLK), .RST_N(RST_N), .UPDATE(update),
    .POS(box_x), .DIR(dir_x), .HIT_PULSE(x_hit)
  );

  bounce_axis #(.WIDTH(9), .MAX(Y_MAX), .STEP(STEP), .INIT(INIT_Y)) u_axis_y (
    .CLK(CLK), .RST_N(RST_N), .UPDATE(update),
    .POS(box_y), .DIR(dir_y), .HIT_PULSE(y_hit)
  );

  always_comb begin
    case (pal_q)
      2'd0:    box_colour = PAL0;
      2'd1:    box_colour = PAL1;
      2'd2:    box_colour = PAL2;
      default: box_colour = PAL3;
    endcase
    // Registered position is the pre-update one, so a coinciding REFRESH is tear-free.
    in_box = (11'(bus.ADDRH) >= 11'(box_x)) && (11'(bus.ADDRH) < 11'(box_x) + BOX_W_W) &&
             (11'(bus.ADDRV) >= 11'(box_y)) && (11'(bus.ADDRV) < 11'(box_y) + BOX_H_W);
    colour_d = colour_q;
    if (bus.PIX_EN) begin
      colour_d = in_box ? box_colour : BG_COLOUR;
    end
    state_d  = bus.PAUSE ? ST_PAUSED : ST_RUN;
    hit_d    = x_hit | y_hit;
    corner_d = x_hit & y_hit;
    pal_d    = pal_q + {1'b0, hit_d};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_RUN;
      pal_q    <= 2'd0;
      hit_q    <= 1'b0;
      corner_q <= 1'b0;
      colour_q <= BG_COLOUR;
    end else begin
      state_q  <= state_d;
      pal_q    <= pal_d;
      hit_q    <= hit_d;
      corner_q <= corner_d;
      colour_q <= colour_d;
    end
  end

  assign bus.COLOUR = colour_q;
  assign bus.BOX_X  = box_x;
  assign bus.BOX_Y  = box_y;
  assign bus.HIT    = hit_q;
  assign bus.CORNER = corner_q;

  logic unused_dir;
  assign unused_dir = dir_x ^ dir_y;

endmodule
`default_nettype wire

// File: tb/tb_bouncing_box_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bouncing_box_renderer
// Brief    : Directed bench for the bouncing box renderer, two configurations.
// Revision : 1.0
// ============================================================================
module tb_bouncing_box_renderer;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  bouncing_box_renderer_if bus();
  bouncing_box_renderer_if bus2();

  bouncing_box_renderer u_dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  bouncing_box_renderer #(.STEP(8), .INIT_X(600), .INIT_Y(440)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus2)
  );

  typedef struct {
    logic [9:0] h;
    logic [8:0] v;
    logic       en;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_refresh(input int n, output int hits, output int corners);
    hits = 0;
    corners = 0;
    for (int i = 0; i < n; i++) begin
      bus.REFRESH = 1'b1;
      tick();
      hits += int'(bus.HIT);
      corners += int'(bus.CORNER);
      bus.REFRESH = 1'b0;
      tick();
      hits += int'(bus.HIT);
      corners += int'(bus.CORNER);
    end
  endtask

  task automatic render(input logic [9:0] h, input logic [8:0] v);
    bus.ADDRH  = h;
    bus.ADDRV  = v;
    bus.PIX_EN = 1'b1;
    tick();
    bus.PIX_EN = 1'b0;
  endtask

  initial begin
    int hits;
    int corners;

    bus.PIX_EN = 0; bus.REFRESH = 0; bus.ADDRH = 0; bus.ADDRV = 0; bus.PAUSE = 0;
    bus2.PIX_EN = 0; bus2.REFRESH = 0; bus2.ADDRH = 0; bus2.ADDRV = 0; bus2.PAUSE = 0;
    #23;
    check("rst_colour", 32'(bus.COLOUR), 32'h00);
    check("rst_box_x", 32'(bus.BOX_X), 32'd304);
    check("rst_box_y", 32'(bus.BOX_Y), 32'd224);
    check("rst_hit", 32'(bus.HIT), 32'd0);
    check("rst_corner", 32'(bus.CORNER), 32'd0);
    RST_N = 1'b1;
    tick();

    // Box occupies [304,336) x [224,256) in PAL0.
    vecs[0] = '{10'd304,  9'd224, 1'b1, 8'hE0};
    vecs[1] = '{10'd336,  9'd224, 1'b1, 8'h00};
    vecs[2] = '{10'd335,  9'd255, 1'b1, 8'hE0};
    vecs[3] = '{10'd303,  9'd224, 1'b1, 8'h00};
    vecs[4] = '{10'd320,  9'd256, 1'b1, 8'h00};
    vecs[5] = '{10'd320,  9'd240, 1'b1, 8'hE0};
    vecs[6] = '{10'd0,    9'd0,   1'b0, 8'hE0};
    vecs[7] = '{10'd1000, 9'd0,   1'b0, 8'hE0};
    vecs[8] = '{10'd1000, 9'd0,   1'b1, 8'h00};
    vecs[9] = '{10'd320,  9'd240, 1'b0, 8'h00};
    for (int i = 0; i < 10; i++) begin
      bus.ADDRH  = vecs[i].h;
      bus.ADDRV  = vecs[i].v;
      bus.PIX_EN = vecs[i].en;
      tick();
      check($sformatf("vec%0d_colour", i), 32'(bus.COLOUR), 32'(vecs[i].exp));
    end
    bus.PIX_EN = 1'b0;

    // Bottom wall on frame 56.
    do_refresh(56, hits, corners);
    check("f56_box_y", 32'(bus.BOX_Y), 32'd448);
    check("f56_box_x", 32'(bus.BOX_X), 32'd528);
    check("f56_hits", 32'(hits), 32'd1);
    check("f56_corners", 32'(corners), 32'd0);
    render(10'd528, 9'd448);
    check("f56_pal1", 32'(bus.COLOUR), 32'h1C);

    // Right wall on frame 76, Y now travelling up.
    do_refresh(20, hits, corners);
    check("f76_box_x", 32'(bus.BOX_X), 32'd608);
    check("f76_box_y", 32'(bus.BOX_Y), 32'd368);
    check("f76_hits", 32'(hits), 32'd1);
    render(10'd639, 9'd399);
    check("f76_pal2", 32'(bus.COLOUR), 32'h03);

    // Corner hit on the second configuration.
    bus2.REFRESH = 1'b1;
    tick();
    bus2.REFRESH = 1'b0;
    check("corner_box_x", 32'(bus2.BOX_X), 32'd608);
    check("corner_box_y", 32'(bus2.BOX_Y), 32'd448);
    check("corner_hit", 32'(bus2.HIT), 32'd1);
    check("corner_corner", 32'(bus2.CORNER), 32'd1);
    bus2.ADDRH = 10'd608; bus2.ADDRV = 9'd448; bus2.PIX_EN = 1'b1;
    tick();
    bus2.PIX_EN = 1'b0;
    check("corner_hit_clear", 32'(bus2.HIT), 32'd0);
    check("corner_corner_clear", 32'(bus2.CORNER), 32'd0);
    check("corner_pal1", 32'(bus2.COLOUR), 32'h1C);

    // Pause freezes everything.
    bus.PAUSE = 1'b1;
    tick();
    do_refresh(10, hits, corners);
    check("pause_box_x", 32'(bus.BOX_X), 32'd608);
    check("pause_box_y", 32'(bus.BOX_Y), 32'd368);
    check("pause_hits", 32'(hits), 32'd0);
    bus.PAUSE = 1'b0;
    tick();
    do_refresh(1, hits, corners);
    check("resume_box_x", 32'(bus.BOX_X), 32'd604);
    check("resume_box_y", 32'(bus.BOX_Y), 32'd364);
    render(10'd604, 9'd364);
    check("resume_pal2", 32'(bus.COLOUR), 32'h03);

    // REFRESH with a pixel: (635,364) is inside the old box only.
    bus.ADDRH = 10'd635; bus.ADDRV = 9'd364; bus.PIX_EN = 1'b1; bus.REFRESH = 1'b1;
    tick();
    bus.REFRESH = 1'b0;
    check("coinc_old_pos", 32'(bus.COLOUR), 32'h03);
    check("coinc_box_x", 32'(bus.BOX_X), 32'd600);
    tick();
    check("coinc_new_pos", 32'(bus.COLOUR), 32'h00);

    bus.PIX_EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ADDRH = 10'(610 + i);
      bus.ADDRV = 9'd370;
      tick();
      check($sformatf("hold%0d_colour", i), 32'(bus.COLOUR), 32'h00);
    end

    // Asynchronous reset mid-frame.
    do_refresh(20, hits, corners);
    check("f20_box_x", 32'(bus.BOX_X), 32'd520);
    check("f20_box_y", 32'(bus.BOX_Y), 32'd280);
    render(10'd520, 9'd280);
    check("f20_colour", 32'(bus.COLOUR), 32'h03);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_colour", 32'(bus.COLOUR), 32'h00);
    check("arst_box_x", 32'(bus.BOX_X), 32'd304);
    check("arst_box_y", 32'(bus.BOX_Y), 32'd224);
    RST_N = 1'b1;
    tick();
    do_refresh(1, hits, corners);
    check("post_rst_box_x", 32'(bus.BOX_X), 32'd308);
    check("post_rst_box_y", 32'(bus.BOX_Y), 32'd228);
    render(10'd308, 9'd228);
    check("post_rst_pal0", 32'(bus.COLOUR), 32'hE0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
